// File: rtl/bullet_slot_scheduler_if.sv
// Tank-side fire handshake for the bullet slot scheduler:
// fire requests, shooter position/velocity, and grant/deny pulses.
interface bullet_slot_scheduler_if;
    logic       fire1;
    logic       fire2;
    logic [9:0] Tank1X;
    logic [9:0] Tank1Y;
    logic [9:0] Tank2X;
    logic [9:0] Tank2Y;
    logic [3:0] step1X;
    logic [3:0] step1Y;
    logic [3:0] step2X;
    logic [3:0] step2Y;
    logic       grant1;
    logic       grant2;
    logic       deny1;
    logic       deny2;

    modport master (
        output fire1, fire2,
        output Tank1X, Tank1Y, Tank2X, Tank2Y,
        output step1X, step1Y, step2X, step2Y,
        input  grant1, grant2, deny1, deny2
    );

    modport slave (
        input  fire1, fire2,
        input  Tank1X, Tank1Y, Tank2X, Tank2Y,
        input  step1X, step1Y, step2X, step2Y,
        output grant1, grant2, deny1, deny2
    );
endinterface

// File: rtl/bullet_slot_scheduler.sv
// Shared bullet slot pool: grants tank fire requests, moves bullets per frame.
// Define BULLET_SLOT_RR_EN for round-robin contest winner (else tank1 wins).
module bullet_slot_scheduler #(
    parameter int NUM_SLOTS    = 3,
    parameter int MAX_PER_TANK = 2,
    parameter int LIFETIME     = 300,
    parameter int BULLET_SIZE  = 2
) (
    input  logic                      CLK,
    input  logic                      Reset_n,
    input  logic                      frame_tick,
    input  logic [NUM_SLOTS-1:0]      wall_hit,
    bullet_slot_scheduler_if.slave    tank,
    output logic [10*NUM_SLOTS-1:0]   BulletX,
    output logic [10*NUM_SLOTS-1:0]   BulletY,
    output logic [9:0]                BulletS,
    output logic [NUM_SLOTS-1:0]      is_active,
    output logic [NUM_SLOTS-1:0]      owner
);

    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam logic [CW-1:0] MAXC  = CW'(MAX_PER_TANK);
    localparam logic [8:0]    LIFE0 = 9'(LIFETIME);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } slot_st_t;

    slot_st_t    r_st   [NUM_SLOTS];
    logic [9:0]  r_x    [NUM_SLOTS];
    logic [9:0]  r_y    [NUM_SLOTS];
    logic [9:0]  r_sx   [NUM_SLOTS];
    logic [9:0]  r_sy   [NUM_SLOTS];
    logic [8:0]  r_life [NUM_SLOTS];
    logic        r_own  [NUM_SLOTS];
    logic [9:0]  r_bs;

    logic [9:0]  w_nx   [NUM_SLOTS];
    logic [9:0]  w_ny   [NUM_SLOTS];
    logic [8:0]  w_nl   [NUM_SLOTS];
    logic        w_ret  [NUM_SLOTS];

    logic [CW-1:0] w_cnt1;
    logic [CW-1:0] w_cnt2;
    logic [IW-1:0] w_f0;
    logic [IW-1:0] w_f1;
    logic          w_f0_ok;
    logic          w_f1_ok;
    logic          w_e1;
    logic          w_e2;
    logic          w_win2;
    logic          w_take1;
    logic          w_take2;
    logic [IW-1:0] w_slot1;
    logic [IW-1:0] w_slot2;
    logic [9:0]    w_sx1;
    logic [9:0]    w_sy1;
    logic [9:0]    w_sx2;
    logic [9:0]    w_sy2;

    assign w_sx1 = {{6{tank.step1X[3]}}, tank.step1X};
    assign w_sy1 = {{6{tank.step1Y[3]}}, tank.step1Y};
    assign w_sx2 = {{6{tank.step2X[3]}}, tank.step2X};
    assign w_sy2 = {{6{tank.step2Y[3]}}, tank.step2Y};

    // Occupancy per tank and the two lowest idle slots, from current state only,
    // so a slot retiring this cycle is not reusable until the next one.
    always_comb begin
        w_cnt1  = '0;
        w_cnt2  = '0;
        w_f0    = '0;
        w_f1    = '0;
        w_f0_ok = 1'b0;
        w_f1_ok = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_st[i] == S_ACTIVE) begin
                if (r_own[i]) w_cnt2 = w_cnt2 + CW'(1);
                else          w_cnt1 = w_cnt1 + CW'(1);
            end else if (!w_f0_ok) begin
                w_f0    = IW'(i);
                w_f0_ok = 1'b1;
            end else if (!w_f1_ok) begin
                w_f1    = IW'(i);
                w_f1_ok = 1'b1;
            end
        end
    end

    assign w_e1 = tank.fire1 && (w_cnt1 < MAXC);
    assign w_e2 = tank.fire2 && (w_cnt2 < MAXC);

`ifdef BULLET_SLOT_RR_EN
    logic r_rr;
    assign w_win2 = r_rr;
`else
    assign w_win2 = 1'b0;
`endif

    always_comb begin
        w_take1 = 1'b0;
        w_take2 = 1'b0;
        w_slot1 = w_f0;
        w_slot2 = w_f0;
        if (w_e1 && w_e2) begin
            if (w_f0_ok) begin
                if (w_win2) begin
                    w_take2 = 1'b1;
                    w_take1 = w_f1_ok;
                    w_slot1 = w_f1;
                end else begin
                    w_take1 = 1'b1;
                    w_take2 = w_f1_ok;
                    w_slot2 = w_f1;
                end
            end
        end else begin
            w_take1 = w_e1 && w_f0_ok;
            w_take2 = w_e2 && w_f0_ok;
        end
    end

    // Per-frame motion; retire is judged on the post-step values.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_nx[i]  = r_x[i] + r_sx[i];
            w_ny[i]  = r_y[i] + r_sy[i];
            w_nl[i]  = r_life[i] - 9'd1;
            w_ret[i] = (w_nl[i] == 9'd0) ||
                       (w_nx[i] >= 10'd640) ||
                       (w_ny[i] >= 10'd480);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_st[i]   <= S_IDLE;
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_sx[i]   <= '0;
                r_sy[i]   <= '0;
                r_life[i] <= '0;
                r_own[i]  <= 1'b0;
            end
            r_bs        <= '0;
            tank.grant1 <= 1'b0;
            tank.grant2 <= 1'b0;
            tank.deny1  <= 1'b0;
            tank.deny2  <= 1'b0;
        end else begin
            r_bs        <= 10'(BULLET_SIZE);
            tank.grant1 <= w_take1;
            tank.grant2 <= w_take2;
            tank.deny1  <= tank.fire1 && !w_take1;
            tank.deny2  <= tank.fire2 && !w_take2;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_take1 && (w_slot1 == IW'(i))) begin
                    r_st[i]   <= S_ACTIVE;
                    r_x[i]    <= tank.Tank1X;
                    r_y[i]    <= tank.Tank1Y;
                    r_sx[i]   <= w_sx1;
                    r_sy[i]   <= w_sy1;
                    r_life[i] <= LIFE0;
                    r_own[i]  <= 1'b0;
                end else if (w_take2 && (w_slot2 == IW'(i))) begin
                    r_st[i]   <= S_ACTIVE;
                    r_x[i]    <= tank.Tank2X;
                    r_y[i]    <= tank.Tank2Y;
                    r_sx[i]   <= w_sx2;
                    r_sy[i]   <= w_sy2;
                    r_life[i] <= LIFE0;
                    r_own[i]  <= 1'b1;
                end else if (r_st[i] == S_ACTIVE) begin
                    if (frame_tick) begin
                        r_x[i]    <= w_nx[i];
                        r_y[i]    <= w_ny[i];
                        r_life[i] <= w_nl[i];
                    end
                    if (wall_hit[i] || (frame_tick && w_ret[i]))
                        r_st[i] <= S_IDLE;
                end
            end
        end
    end

`ifdef BULLET_SLOT_RR_EN
    // Flip only when a contested arbitration actually granted its winner.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            r_rr <= 1'b0;
        else if (w_e1 && w_e2 && w_f0_ok)
            r_rr <= ~r_rr;
    end
`endif

    always_comb begin
        BulletX   = '0;
        BulletY   = '0;
        is_active = '0;
        owner     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            BulletX[i*10 +: 10] = r_x[i];
            BulletY[i*10 +: 10] = r_y[i];
            is_active[i]        = (r_st[i] == S_ACTIVE);
            owner[i]            = r_own[i];
        end
    end

    assign BulletS = r_bs;

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Directed-vector bench for bullet_slot_scheduler.
module tb_bullet_slot_scheduler;

    logic        CLK;
    logic        Reset_n;
    logic        frame_tick;
    logic [2:0]  wall_hit;
    logic [29:0] BulletX;
    logic [29:0] BulletY;
    logic [9:0]  BulletS;
    logic [2:0]  is_active;
    logic [2:0]  owner;

    int n_chk  = 0;
    int n_pass = 0;

    bullet_slot_scheduler_if bif ();

    bullet_slot_scheduler dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .wall_hit   (wall_hit),
        .tank       (bif),
        .BulletX    (BulletX),
        .BulletY    (BulletY),
        .BulletS    (BulletS),
        .is_active  (is_active),
        .owner      (owner)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic fire(input logic f1, input logic f2);
        bif.fire1 = f1;
        bif.fire2 = f2;
        cyc();
        bif.fire1 = 1'b0;
        bif.fire2 = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #7;
        Reset_n = 1'b1;
        cyc();
    endtask

    task automatic set_t1(input logic [9:0] x, input logic [9:0] y,
                          input logic [3:0] sx, input logic [3:0] sy);
        bif.Tank1X = x;
        bif.Tank1Y = y;
        bif.step1X = sx;
        bif.step1Y = sy;
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        wall_hit   = '0;
        bif.fire1  = 1'b0;
        bif.fire2  = 1'b0;
        set_t1(10'd0, 10'd0, 4'd0, 4'd0);
        bif.Tank2X = 10'd300;
        bif.Tank2Y = 10'd300;
        bif.step2X = 4'd1;
        bif.step2Y = 4'd0;
        #12;
        chk("rst_active", 32'(is_active), 32'd0);
        chk("rst_bx", 32'(BulletX), 32'd0);
        chk("rst_bs", 32'(BulletS), 32'd0);
        chk("rst_grant1", 32'(bif.grant1), 32'd0);
        Reset_n = 1'b1;
        cyc();
        chk("bs_after_rst", 32'(BulletS), 32'd2);

        // spawn and move
        set_t1(10'd100, 10'd200, 4'd2, 4'd0);
        fire(1'b1, 1'b0);
        chk("t1_grant1", 32'(bif.grant1), 32'd1);
        chk("t1_deny1", 32'(bif.deny1), 32'd0);
        chk("t1_active", 32'(is_active), 32'b001);
        chk("t1_x0", 32'(BulletX[9:0]), 32'd100);
        chk("t1_y0", 32'(BulletY[9:0]), 32'd200);
        cyc();
        chk("t1_grant_pulse", 32'(bif.grant1), 32'd0);
        tick();
        tick();
        tick();
        chk("t1_x0_3tick", 32'(BulletX[9:0]), 32'd106);
        chk("t1_y0_3tick", 32'(BulletY[9:0]), 32'd200);

        // per-tank cap
        fire(1'b1, 1'b0);
        chk("t2_grant1b", 32'(bif.grant1), 32'd1);
        fire(1'b1, 1'b0);
        chk("t2_deny1", 32'(bif.deny1), 32'd1);
        chk("t2_nogrant1", 32'(bif.grant1), 32'd0);
        chk("t2_active", 32'(is_active), 32'b011);
        chk("t2_owner", 32'(owner), 32'b000);

        // contested fire, one free slot
        do_reset();
        fire(1'b1, 1'b0);
        fire(1'b0, 1'b1);
        chk("t3_setup_owner", 32'(owner), 32'b010);
        fire(1'b1, 1'b1);
        chk("t3a_grant1", 32'(bif.grant1), 32'd1);
        chk("t3a_deny2", 32'(bif.deny2), 32'd1);
        chk("t3a_owner", 32'(owner), 32'b010);
        chk("t3a_active", 32'(is_active), 32'b111);
        wall_hit = 3'b100;
        cyc();
        wall_hit = 3'b000;
        chk("t3_wall2", 32'(is_active), 32'b011);
        fire(1'b1, 1'b1);
`ifdef BULLET_SLOT_RR_EN
        chk("t3b_grant2", 32'(bif.grant2), 32'd1);
        chk("t3b_deny1", 32'(bif.deny1), 32'd1);
        chk("t3b_owner", 32'(owner), 32'b110);
`else
        chk("t3b_grant1", 32'(bif.grant1), 32'd1);
        chk("t3b_deny2", 32'(bif.deny2), 32'd1);
        chk("t3b_owner", 32'(owner), 32'b010);
`endif

        // off-screen exits
        do_reset();
        set_t1(10'd636, 10'd100, 4'd4, 4'd0);
        fire(1'b1, 1'b0);
        chk("t4_x636", 32'(BulletX[9:0]), 32'd636);
        tick();
        chk("t4_x640", 32'(BulletX[9:0]), 32'd640);
        chk("t4_ret_right", 32'(is_active), 32'b000);
        set_t1(10'd1, 10'd100, 4'b1101, 4'd0);
        fire(1'b1, 1'b0);
        chk("t4_spawn_x1", 32'(BulletX[9:0]), 32'd1);
        tick();
        chk("t4_x_wrap", 32'(BulletX[9:0]), 32'd1022);
        chk("t4_ret_wrap", 32'(is_active), 32'b000);

        // lifetime
        set_t1(10'd50, 10'd60, 4'd0, 4'd0);
        fire(1'b1, 1'b0);
        for (int k = 0; k < 299; k++) begin
            tick();
            cyc();
        end
        chk("t5_alive_299", 32'(is_active), 32'b001);
        tick();
        chk("t5_dead_300", 32'(is_active), 32'b000);

        // spawn and tick together
        set_t1(10'd200, 10'd200, 4'd2, 4'd2);
        frame_tick = 1'b1;
        fire(1'b1, 1'b0);
        frame_tick = 1'b0;
        chk("t5_nomove_x", 32'(BulletX[9:0]), 32'd200);
        tick();
        chk("t5_move_x", 32'(BulletX[9:0]), 32'd202);
        chk("t5_move_y", 32'(BulletY[9:0]), 32'd202);

        // wall hit mid-frame
        fire(1'b0, 1'b1);
        chk("t5_slot1_on", 32'(is_active), 32'b011);
        chk("t5_slot1_x", 32'(BulletX[19:10]), 32'd300);
        wall_hit = 3'b010;
        cyc();
        wall_hit = 3'b000;
        chk("t5_wall1", 32'(is_active), 32'b001);

        // retire and fire in same cycle
        fire(1'b0, 1'b1);
        fire(1'b0, 1'b1);
        chk("t6_full", 32'(is_active), 32'b111);
        wall_hit = 3'b001;
        fire(1'b1, 1'b0);
        wall_hit = 3'b000;
        chk("t6_deny_freed", 32'(bif.deny1), 32'd1);
        chk("t6_freed", 32'(is_active), 32'b110);
        fire(1'b1, 1'b0);
        chk("t6_refill", 32'(is_active), 32'b111);
        chk("t6_owner", 32'(owner), 32'b110);

        // async reset mid-cycle
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_active", 32'(is_active), 32'd0);
        chk("t6_rst_owner", 32'(owner), 32'd0);
        chk("t6_rst_bx", 32'(BulletX), 32'd0);
        chk("t6_rst_by", 32'(BulletY), 32'd0);
        chk("t6_rst_bs", 32'(BulletS), 32'd0);
        #4;
        Reset_n = 1'b1;
        cyc();
        fire(1'b0, 1'b1);
        chk("t6_grant2", 32'(bif.grant2), 32'd1);
        chk("t6_after_active", 32'(is_active), 32'b001);
        chk("t6_after_owner", 32'(owner), 32'b001);
        chk("t6_after_x", 32'(BulletX[9:0]), 32'd300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
